// File: rtl/vga_pkg.sv
// Shared scanout types: pixel/address widths, display source and scheduler state.
package vga_pkg;
  localparam int ADDR_W  = 20;
  localparam int COLOR_W = 3;

  typedef enum logic {
    SRC_F1 = 1'b0,
    SRC_F2 = 1'b1
  } src_e;

  typedef enum logic [1:0] {
    SHOW_F1 = 2'd0,
    PEND_F2 = 2'd1,
    SHOW_F2 = 2'd2,
    PEND_F1 = 2'd3
  } sched_state_e;
endpackage

// File: rtl/button_debounce.sv
// Push-button conditioner: two-flop synchroniser, down-counting stability timer,
// one-cycle pulse on each accepted press (release is silent).
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic sysclk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic press
);
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic stable_q, stable_d;
  logic press_q, press_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // The timer reloads whenever the sampled level agrees with the accepted one,
  // so any bounce back restarts the full window.
  always_comb begin
    sync1_d  = btn_raw;
    sync2_d  = sync1_q;
    stable_d = stable_q;
    press_d  = 1'b0;
    cnt_d    = CNT_LOAD;
    if (sync2_q != stable_q) begin
      if (cnt_q == '0) begin
        stable_d = sync2_q;
        press_d  = sync2_q;
      end else begin
        cnt_d = cnt_q - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge sysclk) begin
    if (!rst_n) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      press_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      stable_q <= stable_d;
      press_q  <= press_d;
      cnt_q    <= cnt_d;
    end
  end

  assign press = press_q;
endmodule

// File: rtl/display_source_scheduler.sv
// Frame-synchronous source switch between F1 VRAM and F2 GPU with latency-matched pixel pipe.
// Optional: define BLANK_ON_SWITCH_EN to blank one frame after every committed switch.
//
// state   | meaning
// SHOW_F1 | Function 1 on screen, no request
// PEND_F2 | Function 1 on screen, switch to F2 waits for frame_start
// SHOW_F2 | Function 2 on screen, no request
// PEND_F1 | Function 2 on screen, switch to F1 waits for frame_start
module display_source_scheduler #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int ADDR_W          = vga_pkg::ADDR_W,
  parameter int COLOR_W         = vga_pkg::COLOR_W,
  parameter int F2_LAT          = 1
) (
  input  logic               sysclk,
  input  logic               rst_n,
  input  logic               change_button,
  input  logic               frame_start,
  input  logic               scan_valid,
  input  logic [ADDR_W-1:0]  scan_addr,
  input  logic [COLOR_W-1:0] f1_color,
  output logic [ADDR_W-1:0]  f2_addr,
  input  logic [COLOR_W-1:0] f2_color,
  output logic [COLOR_W-1:0] pix_color,
  output logic               pix_valid,
  output logic               active_src,
  output logic               switch_pending
);
  import vga_pkg::*;

`ifdef BLANK_ON_SWITCH_EN
  localparam bit BLANK_EN = 1'b1;
`else
  localparam bit BLANK_EN = 1'b0;
`endif

  sched_state_e state_q, state_d;
  src_e         cur_src;
  logic         press;
  logic         commit;
  logic         blank_q, blank_d;
  logic [ADDR_W-1:0]              f2_addr_q, f2_addr_d;
  logic [F2_LAT:0]                vld_q, vld_d;
  logic [F2_LAT:0]                src_q, src_d;
  logic [F2_LAT:0][COLOR_W-1:0]   f1_pipe_q, f1_pipe_d;

  button_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .sysclk (sysclk),
    .rst_n  (rst_n),
    .btn_raw(change_button),
    .press  (press)
  );

  // frame_start has priority in PEND so a coincident press cannot cancel a commit.
  always_comb begin
    state_d = state_q;
    commit  = 1'b0;
    unique case (state_q)
      SHOW_F1: if (press) state_d = PEND_F2;
      PEND_F2: begin
        if (frame_start) begin
          state_d = SHOW_F2;
          commit  = 1'b1;
        end else if (press) begin
          state_d = SHOW_F1;
        end
      end
      SHOW_F2: if (press) state_d = PEND_F1;
      PEND_F1: begin
        if (frame_start) begin
          state_d = SHOW_F1;
          commit  = 1'b1;
        end else if (press) begin
          state_d = SHOW_F2;
        end
      end
      default: state_d = SHOW_F1;
    endcase
  end

  assign cur_src        = (state_q == SHOW_F2 || state_q == PEND_F1) ? SRC_F2 : SRC_F1;
  assign active_src     = cur_src;
  assign switch_pending = (state_q == PEND_F2) || (state_q == PEND_F1);

  always_comb begin
    blank_d = blank_q;
    if (commit) begin
      blank_d = BLANK_EN;
    end else if (frame_start) begin
      blank_d = 1'b0;
    end
  end

  // Source select travels with each pixel so a switch never mixes sources mid-pipe.
  always_comb begin
    f2_addr_d = scan_addr;
    vld_d     = {vld_q[F2_LAT-1:0], scan_valid};
    src_d     = {src_q[F2_LAT-1:0], cur_src == SRC_F2};
    f1_pipe_d = {f1_pipe_q[F2_LAT-1:0], f1_color};
  end

  always_comb begin
    pix_valid = vld_q[F2_LAT];
    pix_color = '0;
    if (vld_q[F2_LAT] && !blank_q) begin
      pix_color = src_q[F2_LAT] ? f2_color : f1_pipe_q[F2_LAT];
    end
  end

  assign f2_addr = f2_addr_q;

  always_ff @(posedge sysclk) begin
    if (!rst_n) begin
      state_q   <= SHOW_F1;
      blank_q   <= 1'b0;
      f2_addr_q <= '0;
      vld_q     <= '0;
      src_q     <= '0;
      f1_pipe_q <= '0;
    end else begin
      state_q   <= state_d;
      blank_q   <= blank_d;
      f2_addr_q <= f2_addr_d;
      vld_q     <= vld_d;
      src_q     <= src_d;
      f1_pipe_q <= f1_pipe_d;
    end
  end
endmodule
